// File: rtl/machine_csr_unit.sv
// rtl/machine_csr_unit.sv - machine-mode CSR file and trap controller with vectored interrupts.
// Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters and mcountinhibit.
module machine_csr_unit #(
  parameter int unsigned NUM_IRQ       = 4,
  parameter logic [15:0] IRQ_EDGE_MASK = 16'h0000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [11:0]        i_csr_address,
  input  logic               i_csr_write_enable,
  input  logic [31:0]        i_csr_write_data,
  input  logic [2:0]         i_csr_op,
  output logic [31:0]        o_csr_read_data,
  input  logic               i_exception_enable,
  input  logic [31:0]        i_exception_program_counter,
  input  logic [31:0]        i_exception_cause,
  input  logic [31:0]        i_exception_value,
  input  logic               i_machine_return_enable,
  input  logic               i_instruction_retired,
  input  logic               i_software_interrupt_request,
  input  logic               i_timer_interrupt_request,
  input  logic [NUM_IRQ-1:0] i_local_interrupt_request,
  output logic               o_interrupt_enable,
  output logic [31:0]        o_trap_target,
  output logic [31:0]        o_mepc_out
);
  localparam logic [NUM_IRQ-1:0] EDGE = IRQ_EDGE_MASK[NUM_IRQ-1:0];
  localparam logic [31:0] MIE_MASK = 32'(((64'd1 << NUM_IRQ) - 64'd1) << 16) | 32'h0000_0088;

  logic               r_mstatus_mie, r_mstatus_mpie;
  logic [31:0]        r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [NUM_IRQ-1:0] r_edge_pend, r_irq_prev;

  logic [NUM_IRQ-1:0] w_local_pend, w_rise, w_trap_clr, w_mip_clr, w_irq_onehot;
  logic [31:0]        w_mip, w_pend, w_rdata, w_new, w_base, w_cause;
  logic [4:0]         w_code;
  logic               w_hit, w_fire, w_sw_we, w_unused_ok;

`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle, r_minstret, w_mcycle_next, w_minstret_next;
  logic [1:0]  r_inhibit;
  assign w_unused_ok = ^{i_csr_op[2], i_exception_program_counter[1:0]};
`else
  assign w_unused_ok = ^{i_csr_op[2], i_exception_program_counter[1:0], i_instruction_retired};
`endif

  // Edge lines report their latch, level lines mirror the request input.
  assign w_local_pend = (r_edge_pend & EDGE) | (i_local_interrupt_request & ~EDGE);
  assign w_mip  = (32'(w_local_pend) << 16)
                | {24'd0, i_timer_interrupt_request, 3'd0, i_software_interrupt_request, 3'd0};
  assign w_pend = r_mie & w_mip;

  // Scan from lowest priority upward so the highest-priority source wins.
  always_comb begin
    w_hit        = 1'b0;
    w_code       = 5'd0;
    w_irq_onehot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_pend[16+i]) begin
        w_hit           = 1'b1;
        w_code          = 5'(16 + i);
        w_irq_onehot    = '0;
        w_irq_onehot[i] = 1'b1;
      end
    end
    if (w_pend[7]) begin
      w_hit        = 1'b1;
      w_code       = 5'd7;
      w_irq_onehot = '0;
    end
    if (w_pend[3]) begin
      w_hit        = 1'b1;
      w_code       = 5'd3;
      w_irq_onehot = '0;
    end
  end

  assign w_fire     = r_mstatus_mie & w_hit;
  assign w_trap_clr = w_fire ? (w_irq_onehot & EDGE) : '0;
  assign w_base     = {r_mtvec[31:2], 2'b00};
  assign w_cause    = w_fire ? {1'b1, 26'd0, w_code} : i_exception_cause;

  always_comb begin
    o_trap_target = 32'd0;
    if (w_fire)
      o_trap_target = r_mtvec[0] ? (w_base + {25'd0, w_code, 2'b00}) : w_base;
    else if (i_exception_enable)
      o_trap_target = w_base;
  end

  assign o_interrupt_enable = w_fire;
  assign o_mepc_out         = r_mepc;

  always_comb begin
    w_rdata = 32'd0;
    case (i_csr_address)
      12'h300: w_rdata = {19'd0, 2'b11, 3'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
      12'h304: w_rdata = r_mie;
      12'h305: w_rdata = r_mtvec;
      12'h340: w_rdata = r_mscratch;
      12'h341: w_rdata = r_mepc;
      12'h342: w_rdata = r_mcause;
      12'h343: w_rdata = r_mtval;
      12'h344: w_rdata = w_mip;
`ifdef CSR_COUNTERS_EN
      12'h320:          w_rdata = {29'd0, r_inhibit[1], 1'b0, r_inhibit[0]};
      12'hB00, 12'hC00: w_rdata = r_mcycle[31:0];
      12'hB80, 12'hC80: w_rdata = r_mcycle[63:32];
      12'hB02, 12'hC02: w_rdata = r_minstret[31:0];
      12'hB82, 12'hC82: w_rdata = r_minstret[63:32];
`endif
      default: w_rdata = 32'd0;
    endcase
  end
  assign o_csr_read_data = w_rdata;

  always_comb begin
    case (i_csr_op[1:0])
      2'b10:   w_new = w_rdata | i_csr_write_data;
      2'b11:   w_new = w_rdata & ~i_csr_write_data;
      default: w_new = i_csr_write_data;
    endcase
  end

  assign w_sw_we   = i_csr_write_enable & ~w_fire & ~i_exception_enable & ~i_machine_return_enable;
  assign w_mip_clr = (w_sw_we && i_csr_address == 12'h344) ? (EDGE & ~w_new[16 +: NUM_IRQ]) : '0;
  assign w_rise    = i_local_interrupt_request & ~r_irq_prev & EDGE;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= 32'd0;
      r_mtvec        <= 32'd0;
      r_mscratch     <= 32'd0;
      r_mepc         <= 32'd0;
      r_mcause       <= 32'd0;
      r_mtval        <= 32'd0;
      r_edge_pend    <= '0;
      r_irq_prev     <= '0;
    end else begin
      r_irq_prev  <= i_local_interrupt_request;
      r_edge_pend <= (r_edge_pend & ~w_trap_clr & ~w_mip_clr) | w_rise;
      if (w_fire || i_exception_enable) begin
        r_mepc         <= {i_exception_program_counter[31:2], 2'b00};
        r_mcause       <= w_cause;
        r_mtval        <= w_fire ? 32'd0 : i_exception_value;
        r_mstatus_mpie <= r_mstatus_mie;
        r_mstatus_mie  <= 1'b0;
      end else if (i_machine_return_enable) begin
        r_mstatus_mie  <= r_mstatus_mpie;
        r_mstatus_mpie <= 1'b1;
      end else if (w_sw_we) begin
        case (i_csr_address)
          12'h300: begin
            r_mstatus_mie  <= w_new[3];
            r_mstatus_mpie <= w_new[7];
          end
          12'h304: r_mie      <= w_new & MIE_MASK;
          12'h305: r_mtvec    <= {w_new[31:2], 1'b0, w_new[0]};
          12'h340: r_mscratch <= w_new;
          12'h341: r_mepc     <= {w_new[31:2], 2'b00};
          12'h342: r_mcause   <= w_new;
          12'h343: r_mtval    <= w_new;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  // A software write to one half replaces that half of the incremented value.
  always_comb begin
    w_mcycle_next   = r_mcycle + {63'd0, ~r_inhibit[0]};
    w_minstret_next = r_minstret + {63'd0, i_instruction_retired & ~r_inhibit[1]};
    if (w_sw_we) begin
      case (i_csr_address)
        12'hB00: w_mcycle_next[31:0]    = w_new;
        12'hB80: w_mcycle_next[63:32]   = w_new;
        12'hB02: w_minstret_next[31:0]  = w_new;
        12'hB82: w_minstret_next[63:32] = w_new;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
      r_inhibit  <= 2'b00;
    end else begin
      r_mcycle   <= w_mcycle_next;
      r_minstret <= w_minstret_next;
      if (w_sw_we && i_csr_address == 12'h320)
        r_inhibit <= {w_new[2], w_new[0]};
    end
  end
`endif

endmodule

// File: tb/tb_machine_csr_unit.sv
// tb/tb_machine_csr_unit.sv - randomized bench for machine_csr_unit against an architectural model.
module tb_machine_csr_unit;
  localparam int N = 4;
  localparam logic [N-1:0] EM = 4'b0101;

  logic          i_clk = 1'b0, i_rst = 1'b1;
  logic [11:0]   i_csr_address = '0;
  logic          i_csr_write_enable = 1'b0;
  logic [31:0]   i_csr_write_data = '0;
  logic [2:0]    i_csr_op = '0;
  logic [31:0]   o_csr_read_data;
  logic          i_exception_enable = 1'b0;
  logic [31:0]   i_exception_program_counter = '0, i_exception_cause = '0, i_exception_value = '0;
  logic          i_machine_return_enable = 1'b0, i_instruction_retired = 1'b0;
  logic          i_software_interrupt_request = 1'b0, i_timer_interrupt_request = 1'b0;
  logic [N-1:0]  i_local_interrupt_request = '0;
  logic          o_interrupt_enable;
  logic [31:0]   o_trap_target, o_mepc_out;

  machine_csr_unit #(.NUM_IRQ(N), .IRQ_EDGE_MASK(16'h0005)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_csr_address(i_csr_address),
    .i_csr_write_enable(i_csr_write_enable), .i_csr_write_data(i_csr_write_data),
    .i_csr_op(i_csr_op), .o_csr_read_data(o_csr_read_data),
    .i_exception_enable(i_exception_enable),
    .i_exception_program_counter(i_exception_program_counter),
    .i_exception_cause(i_exception_cause), .i_exception_value(i_exception_value),
    .i_machine_return_enable(i_machine_return_enable),
    .i_instruction_retired(i_instruction_retired),
    .i_software_interrupt_request(i_software_interrupt_request),
    .i_timer_interrupt_request(i_timer_interrupt_request),
    .i_local_interrupt_request(i_local_interrupt_request),
    .o_interrupt_enable(o_interrupt_enable), .o_trap_target(o_trap_target),
    .o_mepc_out(o_mepc_out));

  always #5 i_clk = ~i_clk;

  int n_checks = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Architectural model: whole-register values, edge latches and counters.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_inh;
  logic [N-1:0] m_latch, m_prev;
  logic [63:0] m_cyc, m_ins;

  task automatic model_reset();
    m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
    m_mcause = 0; m_mtval = 0; m_inh = 0; m_latch = 0; m_prev = 0; m_cyc = 0; m_ins = 0;
  endtask

  function automatic logic [31:0] m_mip();
    logic [31:0] v = 32'd0;
    v[3] = i_software_interrupt_request;
    v[7] = i_timer_interrupt_request;
    for (int i = 0; i < N; i++) v[16+i] = EM[i] ? m_latch[i] : i_local_interrupt_request[i];
    return v;
  endfunction

  function automatic int m_code();
    logic [31:0] p = m_mie & m_mip();
    if (!m_mstatus[3]) return -1;
    if (p[3]) return 3;
    if (p[7]) return 7;
    for (int i = 0; i < N; i++) if (p[16+i]) return 16 + i;
    return -1;
  endfunction

  function automatic logic [31:0] m_target();
    int c = m_code();
    logic [31:0] base = m_mtvec & ~32'h3;
    if (c >= 0) return m_mtvec[0] ? base + 32'(4 * c) : base;
    if (i_exception_enable) return base;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip();
`ifdef CSR_COUNTERS_EN
      12'h320:          return m_inh;
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic enter_trap(input logic [31:0] cause, input logic [31:0] val);
    m_mepc    = i_exception_program_counter & ~32'h3;
    m_mcause  = cause;
    m_mtval   = val;
    m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
  endtask

  task automatic m_update();
    int code;
    logic [31:0] rd, nv;
    logic [N-1:0] rise;
    logic sw_we;
    logic [63:0] nc, ni;
    if (i_rst) begin model_reset(); return; end
    code = m_code();
    rd = m_read(i_csr_address);
    case (i_csr_op[1:0])
      2'b10:   nv = rd | i_csr_write_data;
      2'b11:   nv = rd & ~i_csr_write_data;
      default: nv = i_csr_write_data;
    endcase
    rise  = i_local_interrupt_request & ~m_prev & EM;
    sw_we = i_csr_write_enable && code < 0 && !i_exception_enable && !i_machine_return_enable;
    nc = m_cyc + (m_inh[0] ? 64'd0 : 64'd1);
    ni = m_ins + ((i_instruction_retired && !m_inh[2]) ? 64'd1 : 64'd0);
    if (code >= 0) begin
      enter_trap(32'h8000_0000 | 32'(code), 32'd0);
      if (code >= 16) m_latch[code-16] = 1'b0;
    end else if (i_exception_enable) begin
      enter_trap(i_exception_cause, i_exception_value);
    end else if (i_machine_return_enable) begin
      m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
    end else if (sw_we) begin
      case (i_csr_address)
        12'h300: m_mstatus  = 32'h1800 | (nv & 32'h88);
        12'h304: m_mie      = nv & 32'h000F_0088;
        12'h305: m_mtvec    = nv & ~32'h2;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~32'h3;
        12'h342: m_mcause   = nv;
        12'h343: m_mtval    = nv;
        12'h344: m_latch    = m_latch & (nv[16 +: N] | ~EM);
`ifdef CSR_COUNTERS_EN
        12'h320: m_inh       = nv & 32'h5;
        12'hB00: nc[31:0]    = nv;
        12'hB80: nc[63:32]   = nv;
        12'hB02: ni[31:0]    = nv;
        12'hB82: ni[63:32]   = nv;
`endif
        default: ;
      endcase
    end
    m_latch = m_latch | rise;
    m_prev  = i_local_interrupt_request;
    m_cyc   = nc;
    m_ins   = ni;
  endtask

  always @(negedge i_clk) begin
    chk("rdata", o_csr_read_data, m_read(i_csr_address));
    chk("irq_en", {31'd0, o_interrupt_enable}, (m_code() >= 0) ? 32'd1 : 32'd0);
    chk("trap_target", o_trap_target, m_target());
    chk("mepc_out", o_mepc_out, m_mepc);
  end

  task automatic cycle();
    @(posedge i_clk);
    m_update();
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input logic [2:0] op);
    i_csr_address = a; i_csr_write_data = d; i_csr_op = op; i_csr_write_enable = 1'b1;
    cycle();
    i_csr_write_enable = 1'b0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    i_csr_address = a;
    #1;
    chk(name, o_csr_read_data, exp);
  endtask

  logic [11:0] addrs [18] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h343, 12'h344, 12'h320, 12'hB00, 12'hB80, 12'hB02,
                              12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7FF};

  initial begin
    model_reset();
    repeat (2) cycle();
    i_rst = 1'b0;
    rd("rst_mstatus", 12'h300, 32'h1800);
    rd("rst_mtvec", 12'h305, 32'h0);
    rd("rst_mepc", 12'h341, 32'h0);
    cycle();
    rd("rst_mip", 12'h344, 32'h0);
    chk("rst_target", o_trap_target, 32'h0);

    csr_wr(12'h305, 32'h1001, 3'b001);
    csr_wr(12'h304, 32'h80, 3'b001);
    csr_wr(12'h300, 32'h8, 3'b001);
    i_timer_interrupt_request = 1'b1;
    #1;
    chk("tmr_fire", {31'd0, o_interrupt_enable}, 32'd1);
    chk("tmr_target", o_trap_target, 32'h101C);
    cycle();
    i_timer_interrupt_request = 1'b0;
    rd("tmr_mcause", 12'h342, 32'h8000_0007);
    rd("tmr_mstatus", 12'h300, 32'h1880);

    i_local_interrupt_request = 4'b0001;
    cycle();
    i_local_interrupt_request = 4'b0000;
    cycle();
    rd("edge_set", 12'h344, 32'h1_0000);
    cycle();
    rd("edge_hold", 12'h344, 32'h1_0000);
    csr_wr(12'h344, 32'h1_0000, 3'b011);
    rd("edge_clr", 12'h344, 32'h0);

    csr_wr(12'h300, 32'h8, 3'b001);
    i_timer_interrupt_request = 1'b1; i_exception_enable = 1'b1;
    i_exception_cause = 32'd2; i_exception_value = 32'hDEAD; i_exception_program_counter = 32'h400;
    cycle();
    i_timer_interrupt_request = 1'b0; i_exception_enable = 1'b0;
    rd("race_mcause", 12'h342, 32'h8000_0007);
    rd("race_mtval", 12'h343, 32'h0);
    chk("race_mepc", o_mepc_out, 32'h400);
    i_machine_return_enable = 1'b1;
    cycle();
    i_machine_return_enable = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h1888);

    csr_wr(12'h300, 32'h0, 3'b001);
    csr_wr(12'h304, 32'h1_0088, 3'b001);
    i_software_interrupt_request = 1'b1; i_local_interrupt_request = 4'b0001;
    cycle();
    i_local_interrupt_request = 4'b0000;
    cycle();
    csr_wr(12'h300, 32'h8, 3'b001);
    #1;
    chk("sw_target", o_trap_target, 32'h100C);
    cycle();
    i_software_interrupt_request = 1'b0;
    rd("sw_mcause", 12'h342, 32'h8000_0003);
    csr_wr(12'h300, 32'h8, 3'b001);
    #1;
    chk("loc_target", o_trap_target, 32'h1040);
    cycle();
    rd("loc_mcause", 12'h342, 32'h8000_0010);
    rd("loc_mip", 12'h344, 32'h0);

`ifdef CSR_COUNTERS_EN
    csr_wr(12'hB80, 32'h0, 3'b001);
    csr_wr(12'hB00, 32'hFFFF_FFFF, 3'b001);
    rd("cyc_lo_set", 12'hB00, 32'hFFFF_FFFF);
    rd("cyc_hi_set", 12'hB80, 32'h0);
    cycle();
    rd("cyc_hi_carry", 12'hB80, 32'h1);
    rd("cyc_lo_wrap", 12'hB00, 32'h0);
    csr_wr(12'h320, 32'h5, 3'b001);
    i_instruction_retired = 1'b1;
    repeat (3) cycle();
    i_instruction_retired = 1'b0;
    rd("inh_cyc_lo", 12'hB00, 32'h1);
    rd("inh_cyc_hi", 12'hC80, 32'h1);
    rd("inh_instret", 12'hB02, 32'h0);
`else
    csr_wr(12'hB00, 32'h1234, 3'b001);
    rd("nocnt_b00", 12'hB00, 32'h0);
    rd("nocnt_320", 12'h320, 32'h0);
`endif

    csr_wr(12'h300, 32'h8, 3'b001);
    i_timer_interrupt_request = 1'b1;
    #3;
    i_rst = 1'b1;
    model_reset();
    cycle();
    i_rst = 1'b0; i_timer_interrupt_request = 1'b0;
    rd("abort_mstatus", 12'h300, 32'h1800);
    rd("abort_mcause", 12'h342, 32'h0);
    chk("abort_mepc", o_mepc_out, 32'h0);

    for (int k = 0; k < 3000; k++) begin
      i_rst = ($urandom_range(0, 299) == 0);
      if (i_rst) model_reset();
      i_csr_address      = addrs[$urandom_range(0, 17)];
      i_csr_write_enable = ($urandom_range(0, 2) == 0);
      i_csr_op           = 3'($urandom);
      i_csr_write_data   = $urandom_range(0, 1) ? $urandom : ($urandom & 32'h000F_0089);
      i_exception_enable = ($urandom_range(0, 9) == 0);
      i_exception_cause  = $urandom_range(0, 15);
      i_exception_value  = $urandom;
      i_exception_program_counter = $urandom;
      i_machine_return_enable      = ($urandom_range(0, 9) == 0);
      i_instruction_retired        = 1'($urandom);
      i_software_interrupt_request = ($urandom_range(0, 7) == 0);
      i_timer_interrupt_request    = ($urandom_range(0, 7) == 0);
      i_local_interrupt_request    = 4'($urandom) & 4'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/machine_csr_unit.md
# machine_csr_unit

Parametrised machine-mode CSR file and trap controller for the RISC-V core, with configurable local interrupt lines, edge/level pending logic, vectored trap entry, and optional 64-bit performance counters. Sits beside the decode/writeback stages: serves CSR instructions, records trap state, and gives the fetch logic the trap target and return PC.

## Interface
- NUM_IRQ, 4: number of local interrupt lines, 1..16; mapped to mip/mie bits 16..16+NUM_IRQ-1.
- IRQ_EDGE_MASK, 0: per-line mode, bit i = 1 makes local line i edge-triggered (rising), 0 makes it level.
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- csr_address  in  12  CSR address.
- csr_write_enable  in  1  CSR instruction commit strobe.
- csr_write_data  in  32  rs1 or zimm operand.
- csr_op  in  3  funct3; [1:0] 01 RW, 10 RS, 11 RC, 00 treated as RW.
- csr_read_data  out  32  combinational read of csr_address; unmapped addresses read 0.
- exception_enable  in  1  synchronous exception commit.
- exception_program_counter  in  32  PC saved to mepc on any trap.
- exception_cause  in  32  mcause for exceptions.
- exception_value  in  32  mtval for exceptions.
- machine_return_enable  in  1  MRET commit.
- instruction_retired  in  1  one pulse per retired instruction.
- software_interrupt_request  in  1  MSIP source, level.
- timer_interrupt_request  in  1  MTIP source, level.
- local_interrupt_request  in  NUM_IRQ  local sources.
- interrupt_enable  out  1  interrupt trap taken this cycle.
- trap_target  out  32  fetch redirect PC for the trap taken this cycle.
- mepc_out  out  32  current mepc.

## Operation
- Registers: mstatus (0x300; only MIE bit 3, MPIE bit 7 writable, MPP 12:11 read 2'b11), mie (0x304; writable bits 3, 7, 16+), mtvec (0x305; bit 1 forced 0, mode bit 0: 0 direct, 1 vectored), mscratch (0x340), mepc (0x341; bits 1:0 forced 0), mcause (0x342), mtval (0x343), mip (0x344).
- mip bit 3 = software request, bit 7 = timer request, bit 16+i = local pending i. Level lines mirror the input. Edge lines set a latch on a rising edge, sampled against a one-cycle-delayed copy. The latch is cleared by a CSRRC/CSRRW write of 0 to that mip bit, or by trap entry for that cause. All other mip bits are read-only.
- RS/RC new value = csr_read_data OR / AND-NOT write data, then the write mask is applied. An RS/RC with zero write data still writes, which is harmless.
- Fire condition: mstatus.MIE and a nonzero value of (mie AND mip). Priority: MSI (3) > MTI (7) > local 0 > ... > local NUM_IRQ-1. The interrupt cause is {1'b1, 31'(code)}.
- Update priority per cycle: interrupt > exception > MRET > software write. A lower-priority event in the same cycle is dropped; the pipeline flushes and replays it.
- Trap entry (interrupt or exception): mepc <= exception_program_counter, mcause <= cause, MPIE <= MIE, MIE <= 0. mtval <= exception_value for exceptions and 0 for interrupts.
- trap_target: mtvec base for exceptions, or for interrupts in direct mode. In vectored mode an interrupt targets base + 4*code.
- MRET: MIE <= MPIE, MPIE <= 1.

## Timing
- csr_read_data, interrupt_enable and trap_target are combinational from registered state plus level inputs. All state updates on posedge clk.
- An edge-line pending bit is visible in mip one cycle after the rising edge is sampled.
- After trap entry, MIE reads 0 in the next cycle, so back-to-back interrupts cannot fire.
- Reset clears every register and latch to 0, with mtvec = 0. Reset outputs: interrupt_enable = 0, trap_target = 0, mepc_out = 0, csr_read_data = 0 except an mstatus read, which returns 0x1800.
- Reset asserted mid-trap aborts the trap; no partial update survives.

## Configuration
- CSR_COUNTERS_EN defined: adds 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), read-only shadows cycle/instret (0xC00/0xC80/0xC02/0xC82), and mcountinhibit (0x320; bits 0 and 2).
  - mcycle increments every cycle unless inhibited.
  - minstret increments on instruction_retired unless inhibited.
  - A software write to a half takes precedence over that cycle's increment.
  - Carry from the low to the high half is in the same cycle; both halves wrap at 2^64 to 0.
- Undefined: counter addresses read 0 and writes to them are ignored.

## Test plan
- Reset then read 0x300 -> 0x1800. Read 0x305, 0x341, 0x344 -> 0.
- Write mtvec = 0x1001, mie = 0x80, mstatus = 0x8, then raise timer_interrupt_request -> interrupt_enable = 1, trap_target = 0x101C, mcause = 0x80000007, mstatus = 0x1880 next cycle.
- Edge local line 0 (IRQ_EDGE_MASK = 1) with a 1-cycle pulse while MIE = 0 -> mip bit 16 stays set. CSRRC mip with 0x10000 -> bit clears.
- Exception (cause 2, value 0xDEAD) and timer interrupt in the same cycle -> interrupt wins, mtval = 0, mcause = 0x80000007. MRET next -> MIE = 1, MPIE = 1.
- Software and local 0 pending together -> mcause code 3. Clear software -> mcause code 16.
- CSR_COUNTERS_EN: set mcycle low half to 0xFFFFFFFF, high half to 0 -> after 1 cycle high = 1, low = 0. Set mcountinhibit = 0x5 -> both counters hold.
